pulse_width_meter: RTL and testbench

PULSE_WIDTH_METER -- requirements
Module: pulse_width_meter

---
 rtl/slg46620_cnt0_pkg.sv | 32 +++
 rtl/pulse_width_meter_if.sv | 24 ++
 rtl/pwm_edge_detect.sv | 52 +++++
 rtl/pulse_width_meter.sv | 120 ++++++++++++
 tb/tb_pulse_width_meter.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/slg46620_cnt0_pkg.sv
// Shared types for the pulse width meter: measurement modes, FSM states,
// and the helpers that map a mode onto its start and end edges.
package slg46620_cnt0_pkg;

    typedef enum logic [1:0] {
        HIGH_PULSE = 2'b00,
        LOW_PULSE  = 2'b01,
        PERIOD     = 2'b10,
        RESERVED   = 2'b11
    } meas_mode_t;

    typedef enum logic [1:0] {
        PRIME,
        IDLE,
        MEASURE,
        HOLD
    } meas_state_t;

    // RESERVED behaves exactly like HIGH_PULSE.
    function automatic logic is_start_edge(input meas_mode_t mode,
                                           input logic rise,
                                           input logic fall);
        return (mode == LOW_PULSE) ? fall : rise;
    endfunction

    function automatic logic is_end_edge(input meas_mode_t mode,
                                         input logic rise,
                                         input logic fall);
        return (mode == LOW_PULSE || mode == PERIOD) ? rise : fall;
    endfunction

endpackage

// File: rtl/pulse_width_meter_if.sv
// Result channel of the pulse width meter: captured width, overflow flag,
// and the valid/ready handshake that releases it.
interface pulse_width_meter_if #(
    parameter int BIT_WIDTH = 14
);
    logic [BIT_WIDTH-1:0] o_count;
    logic                 o_overflow;
    logic                 o_valid;
    logic                 i_ready;

    modport master (
        output o_count,
        output o_overflow,
        output o_valid,
        input  i_ready
    );

    modport slave (
        input  o_count,
        input  o_overflow,
        input  o_valid,
        output i_ready
    );
endinterface

// File: rtl/pwm_edge_detect.sv
// Edge detector for the pulse width meter. With PULSE_WIDTH_METER_SYNC_EN
// defined, a 2-flop synchronizer sits between i_in and the sampled level s.
module pwm_edge_detect (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_in,
    output logic o_rise,
    output logic o_fall
);

    logic s;
    logic p_q;
    logic p_d;

`ifdef PULSE_WIDTH_METER_SYNC_EN
    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], i_in};
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign s = sync_q[1];
`else
    assign s = i_in;
`endif

    // p tracks s every cycle regardless of what the FSM is doing.
    always_comb begin
        p_d = s;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            p_q <= 1'b0;
        end else begin
            p_q <= p_d;
        end
    end

    assign o_rise = s & ~p_q;
    assign o_fall = ~s & p_q;

endmodule

// File: rtl/pulse_width_meter.sv
// Pulse width meter: measures high width, low width or period of i_in in
// i_clk cycles. PULSE_WIDTH_METER_SYNC_EN enables the input synchronizer.
//
// state   | meaning
// PRIME   | first cycle after reset, edge history loads, edges ignored
// IDLE    | waiting for a start edge
// MEASURE | counting, o_busy high
// HOLD    | result presented, o_valid high until accepted
module pulse_width_meter
    import slg46620_cnt0_pkg::*;
#(
    parameter int BIT_WIDTH = 14
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [1:0] i_edge_mode_select,
    input  logic       i_in,
    output logic       o_busy,
    pulse_width_meter_if.master res
);

    localparam logic [BIT_WIDTH-1:0] CNT_ONE = BIT_WIDTH'(1);
    localparam logic [BIT_WIDTH-1:0] CNT_MAX = {BIT_WIDTH{1'b1}};

    meas_state_t          state_q;
    meas_state_t          state_d;
    meas_mode_t           mode_q;
    meas_mode_t           mode_d;
    logic [BIT_WIDTH-1:0] cnt_q;
    logic [BIT_WIDTH-1:0] cnt_d;
    logic [BIT_WIDTH-1:0] count_q;
    logic [BIT_WIDTH-1:0] count_d;
    logic                 ovf_q;
    logic                 ovf_d;
    logic                 res_ovf_q;
    logic                 res_ovf_d;

    logic rise;
    logic fall;
    logic start_edge;
    logic end_edge;

    pwm_edge_detect u_edge (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_in    (i_in),
        .o_rise  (rise),
        .o_fall  (fall)
    );

    // Start uses the live mode select; the end edge uses the latched mode.
    assign start_edge = is_start_edge(meas_mode_t'(i_edge_mode_select), rise, fall);
    assign end_edge   = is_end_edge(mode_q, rise, fall);

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        count_d   = count_q;
        res_ovf_d = res_ovf_q;

        case (state_q)
            PRIME: begin
                state_d = IDLE;
            end
            IDLE: begin
                if (start_edge) begin
                    state_d = MEASURE;
                    mode_d  = meas_mode_t'(i_edge_mode_select);
                    cnt_d   = CNT_ONE;
                    ovf_d   = 1'b0;
                end
            end
            MEASURE: begin
                if (end_edge) begin
                    state_d   = HOLD;
                    count_d   = cnt_q;
                    res_ovf_d = ovf_q;
                end else if (cnt_q == CNT_MAX) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HOLD: begin
                if (res.i_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = PRIME;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= PRIME;
            mode_q    <= HIGH_PULSE;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            count_q   <= '0;
            res_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            count_q   <= count_d;
            res_ovf_q <= res_ovf_d;
        end
    end

    assign res.o_count    = count_q;
    assign res.o_overflow = res_ovf_q;
    assign res.o_valid    = (state_q == HOLD);
    assign o_busy         = (state_q == MEASURE);

endmodule

// File: tb/tb_pulse_width_meter.sv
// Bench for pulse_width_meter: a 14-bit and a 4-bit instance, a vector table
// of pulses plus directed sequences, results checked through a scoreboard.
module tb_pulse_width_meter;

`ifdef PULSE_WIDTH_METER_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] mode = 2'b00;
    logic       in_a = 1'b0;
    logic       in_b = 1'b0;
    logic       busy_a;
    logic       busy_b;

    pulse_width_meter_if #(.BIT_WIDTH(14)) if_a ();
    pulse_width_meter_if #(.BIT_WIDTH(4))  if_b ();

    pulse_width_meter #(.BIT_WIDTH(14)) dut_a (
        .i_clk              (clk),
        .i_reset            (rst),
        .i_edge_mode_select (mode),
        .i_in               (in_a),
        .o_busy             (busy_a),
        .res                (if_a)
    );

    pulse_width_meter #(.BIT_WIDTH(4)) dut_b (
        .i_clk              (clk),
        .i_reset            (rst),
        .i_edge_mode_select (mode),
        .i_in               (in_b),
        .o_busy             (busy_b),
        .res                (if_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int count;
        int ovf;
    } res_t;

    typedef struct {
        bit         sel;
        logic [1:0] m;
        int         width;
        int         hold;
        int         exp_cnt;
        int         exp_ovf;
    } vec_t;

    res_t q_a[$];
    res_t q_b[$];
    int   total = 0;
    int   bad   = 0;

    logic pva = 1'b0;
    logic pvb = 1'b0;
    int   pca = 0;
    int   pcb = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_in(input bit sel, input logic v);
        if (sel) in_b = v;
        else     in_a = v;
    endtask

    task automatic push(input bit sel, input int c, input int o);
        res_t r;
        r.count = c;
        r.ovf   = o;
        if (sel) q_b.push_back(r);
        else     q_a.push_back(r);
    endtask

    task automatic drive_pulse(input bit sel, input logic [1:0] m, input int w);
        mode = m;
        case (m)
            2'b01: begin
                set_in(sel, 1'b1);
                tick(2 + SYNC_LAT);
                set_in(sel, 1'b0);
                tick(w);
                set_in(sel, 1'b1);
            end
            2'b10: begin
                set_in(sel, 1'b1);
                tick(1);
                set_in(sel, 1'b0);
                tick(w - 1);
                set_in(sel, 1'b1);
                tick(1);
                set_in(sel, 1'b0);
            end
            default: begin
                set_in(sel, 1'b1);
                tick(w);
                set_in(sel, 1'b0);
            end
        endcase
    endtask

    task automatic wait_valid(input bit sel, output int lat);
        lat = 0;
        while (!(sel ? if_b.o_valid : if_a.o_valid) && lat < 100) begin
            tick(1);
            lat++;
        end
        check(sel ? "valid_timeout_b" : "valid_timeout_a",
              int'(sel ? if_b.o_valid : if_a.o_valid), 1);
    endtask

    task automatic ack(input bit sel);
        if (sel) if_b.i_ready = 1'b1;
        else     if_a.i_ready = 1'b1;
        tick(1);
        if_a.i_ready = 1'b0;
        if_b.i_ready = 1'b0;
        check(sel ? "valid_low_after_ack_b" : "valid_low_after_ack_a",
              int'(sel ? if_b.o_valid : if_a.o_valid), 0);
    endtask

    task automatic rest(input bit sel);
        mode = 2'b00;
        set_in(sel, 1'b0);
        tick(2 + SYNC_LAT);
    endtask

    // Scoreboard: one expected record per rising o_valid, count held stable in HOLD.
    initial begin
        res_t r;
        forever begin
            @(negedge clk);
            if (rst) begin
                pva = 1'b0;
                pvb = 1'b0;
            end else begin
                if (if_a.o_valid && !pva) begin
                    if (q_a.size() == 0) begin
                        check("extra_result_a", 1, 0);
                    end else begin
                        r = q_a.pop_front();
                        check("count_a", int'(if_a.o_count), r.count);
                        check("ovf_a", int'(if_a.o_overflow), r.ovf);
                    end
                end else if (if_a.o_valid) begin
                    check("hold_stable_a", int'(if_a.o_count), pca);
                end
                if (if_b.o_valid && !pvb) begin
                    if (q_b.size() == 0) begin
                        check("extra_result_b", 1, 0);
                    end else begin
                        r = q_b.pop_front();
                        check("count_b", int'(if_b.o_count), r.count);
                        check("ovf_b", int'(if_b.o_overflow), r.ovf);
                    end
                end else if (if_b.o_valid) begin
                    check("hold_stable_b", int'(if_b.o_count), pcb);
                end
                pva = if_a.o_valid;
                pca = int'(if_a.o_count);
                pvb = if_b.o_valid;
                pcb = int'(if_b.o_count);
            end
        end
    end

    initial begin
        vec_t vecs[10];
        int   lat;
        int   vseen;

        vecs[0] = '{1'b0, 2'b00,  7,  0,  7, 0};
        vecs[1] = '{1'b0, 2'b01,  5,  3,  5, 0};
        vecs[2] = '{1'b0, 2'b11,  4, -1,  4, 0};
        vecs[3] = '{1'b0, 2'b00,  1,  2,  1, 0};
        vecs[4] = '{1'b0, 2'b10,  2,  0,  2, 0};
        vecs[5] = '{1'b0, 2'b01, 30,  4, 30, 0};
        vecs[6] = '{1'b1, 2'b01, 20,  2, 15, 1};
        vecs[7] = '{1'b1, 2'b00, 14,  1, 14, 0};
        vecs[8] = '{1'b1, 2'b10,  3,  0,  3, 0};
        vecs[9] = '{1'b1, 2'b00, 16,  0, 15, 1};

        if_a.i_ready = 1'b0;
        if_b.i_ready = 1'b0;
        in_a = (SYNC_LAT == 0);   // already at start level when reset releases
        tick(3);
        check("rst_count_a", int'(if_a.o_count), 0);
        check("rst_ovf_a", int'(if_a.o_overflow), 0);
        check("rst_valid_a", int'(if_a.o_valid), 0);
        check("rst_busy_a", int'(busy_a), 0);
        check("rst_count_b", int'(if_b.o_count), 0);
        check("rst_valid_b", int'(if_b.o_valid), 0);
        check("rst_busy_b", int'(busy_b), 0);

        rst = 1'b0;
        tick(5);
        check("no_false_start_busy", int'(busy_a), 0);
        check("no_false_start_valid", int'(if_a.o_valid), 0);
        in_a = 1'b0;
        tick(2 + SYNC_LAT);
        push(1'b0, 3, 0);
        drive_pulse(1'b0, 2'b00, 3);
        wait_valid(1'b0, lat);
        ack(1'b0);
        rest(1'b0);

        for (int i = 0; i < 10; i++) begin
            push(vecs[i].sel, vecs[i].exp_cnt, vecs[i].exp_ovf);
            if (vecs[i].hold < 0) begin
                if (vecs[i].sel) if_b.i_ready = 1'b1;
                else             if_a.i_ready = 1'b1;
            end
            drive_pulse(vecs[i].sel, vecs[i].m, vecs[i].width);
            wait_valid(vecs[i].sel, lat);
            if (vecs[i].hold > 0) tick(vecs[i].hold);
            ack(vecs[i].sel);
            rest(vecs[i].sel);
        end

        // Period of 12, then edges during HOLD including the transfer cycle.
        mode = 2'b10;
        push(1'b0, 12, 0);
        in_a = 1'b1;
        tick(1);
        in_a = 1'b0;
        tick(11);
        in_a = 1'b1;
        tick(1);
        in_a = 1'b0;
        wait_valid(1'b0, lat);
        tick(1);
        in_a = 1'b1;
        tick(1);
        in_a = 1'b0;
        tick(2);
        in_a = 1'b1;
        tick(SYNC_LAT);
        check("hold_still_valid", int'(if_a.o_valid), 1);
        ack(1'b0);
        vseen = 0;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            if (if_a.o_valid || busy_a) vseen++;
        end
        check("hold_edges_ignored", vseen, 0);
        rest(1'b0);

        // Mode select changed mid-measurement must not move the end edge.
        mode = 2'b00;
        push(1'b0, 10, 0);
        in_a = 1'b1;
        tick(4);
        check("busy_in_measure", int'(busy_a), 1);
        mode = 2'b01;
        tick(6);
        in_a = 1'b0;
        wait_valid(1'b0, lat);
        ack(1'b0);
        rest(1'b0);

        // Capture latency from the end of a 9-cycle pulse.
        push(1'b0, 9, 0);
        in_a = 1'b1;
        tick(9);
        in_a = 1'b0;
        wait_valid(1'b0, lat);
        check("capture_latency", lat, 1 + SYNC_LAT);
        ack(1'b0);
        check("idle_not_busy", int'(busy_a), 0);
        rest(1'b0);

        // Reset at cycle 4 of a 10-cycle pulse.
        in_a = 1'b1;
        tick(4);
        rst = 1'b1;
        #1;
        check("abort_count_a", int'(if_a.o_count), 0);
        check("abort_ovf_b", int'(if_b.o_overflow), 0);
        check("abort_valid_a", int'(if_a.o_valid), 0);
        check("abort_busy_a", int'(busy_a), 0);
        if (SYNC_LAT != 0) in_a = 1'b0;
        tick(2);
        rst = 1'b0;
        vseen = 0;
        for (int k = 0; k < 25; k++) begin
            if (k == 4) in_a = 1'b0;
            tick(1);
            if (if_a.o_valid || busy_a) vseen++;
        end
        check("no_result_after_abort", vseen, 0);

        check("pending_a", q_a.size(), 0);
        check("pending_b", q_b.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
